// File: rtl/brq_rvfi_trace_buffer_if.sv
// Retirement-stream input and drain port of the RVFI trace buffer.
interface brq_rvfi_trace_buffer_if;
    localparam int unsigned RecW = 105;

    logic            rvfi_valid;
    logic [31:0]     rvfi_pc_rdata;
    logic [31:0]     rvfi_insn;
    logic [4:0]      rvfi_rd_addr;
    logic [31:0]     rvfi_rd_wdata;
    logic            rvfi_trap;
    logic            rvfi_intr;
    logic [1:0]      rvfi_mode;
    logic            rd_ready_i;
    logic            rd_valid_o;
    logic [RecW-1:0] rd_data_o;

    // Core/consumer side: drives retirements and read-ready.
    modport master (
        output rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
        output rvfi_trap, rvfi_intr, rvfi_mode, rd_ready_i,
        input  rd_valid_o, rd_data_o
    );

    // Trace buffer side.
    modport slave (
        input  rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
        input  rvfi_trap, rvfi_intr, rvfi_mode, rd_ready_i,
        output rd_valid_o, rd_data_o
    );
endinterface

// File: rtl/brq_rvfi_trace_buffer.sv
// On-chip RVFI retirement trace buffer with filter, trigger/post-trigger
// freeze, stop-when-full or circular storage and a FWFT drain port.
module brq_rvfi_trace_buffer #(
    parameter  int unsigned Depth = 16,
    parameter  int unsigned PostW = 8,
    localparam int unsigned LvlW  = $clog2(Depth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    brq_rvfi_trace_buffer_if.slave bus,
    input  logic                  cfg_wrap_i,
    input  logic                  cfg_trap_only_i,
    input  logic                  arm_i,
    input  logic                  clear_i,
    input  logic                  trig_pc_en_i,
    input  logic [31:0]           trig_pc_i,
    input  logic                  trig_on_trap_i,
    input  logic [PostW-1:0]      post_count_i,
    output logic [LvlW-1:0]       level_o,
    output logic [15:0]           drop_cnt_o,
    output logic [1:0]            state_o,
    output logic                  triggered_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned RecW = 105;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StPost   = 2'd2,
        StFrozen = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic [15:0]     drop_q, drop_d;
    logic [PostW-1:0] post_q, post_d;
    logic            trig_q, trig_d;
    logic            rd_valid_q, rd_valid_d;
    logic [RecW-1:0] rd_data_q, rd_data_d;
    logic [RecW-1:0] mem_q [Depth];

    logic [RecW-1:0] rec;
    logic capturing, trig_ev, qual, cap, pop, full, overwrite, drop, wr_en;

    assign rec = {bus.rvfi_pc_rdata, bus.rvfi_insn, bus.rvfi_rd_addr, bus.rvfi_rd_wdata,
                  bus.rvfi_trap, bus.rvfi_intr, bus.rvfi_mode};

    // Capture qualification, buffer bookkeeping and trigger state machine.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        drop_d     = drop_q;
        post_d     = post_q;
        trig_d     = trig_q;

        capturing  = (state_q == StRun) || (state_q == StPost);
        trig_ev    = (state_q == StRun) && bus.rvfi_valid &&
                     ((trig_pc_en_i && (bus.rvfi_pc_rdata == trig_pc_i)) ||
                      (trig_on_trap_i && bus.rvfi_trap));
        qual       = bus.rvfi_valid && capturing &&
                     (!cfg_trap_only_i || bus.rvfi_trap || bus.rvfi_intr);
        // The trigger record is stored even when the filter rejects it.
        cap        = qual || trig_ev;
        pop        = rd_valid_q && bus.rd_ready_i;
        full       = (level_q == LvlW'(Depth));
        overwrite  = cap && full && !pop && cfg_wrap_i;
        drop       = cap && full && !pop && !cfg_wrap_i;
        wr_en      = cap && !drop && !clear_i;

        if (wr_en) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (pop || overwrite) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        if (wr_en && !pop && !overwrite) begin
            level_d = level_q + LvlW'(1);
        end else if (pop && !wr_en) begin
            level_d = level_q - LvlW'(1);
        end
        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        // Dropped records advance trigger/post counting like stored ones.
        unique case (state_q)
            StIdle, StFrozen: begin
                if (arm_i) begin
                    state_d = StRun;
                    post_d  = post_count_i;
                    trig_d  = 1'b0;
                end
            end
            StRun: begin
                if (trig_ev) begin
                    trig_d  = 1'b1;
                    state_d = (post_q == '0) ? StFrozen : StPost;
                end
            end
            StPost: begin
                if (cap) begin
                    post_d = post_q - PostW'(1);
                    if (post_q == PostW'(1)) begin
                        state_d = StFrozen;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear_i) begin
            state_d = StIdle;
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            drop_d  = '0;
            post_d  = '0;
            trig_d  = 1'b0;
        end

        // Registered FWFT head: forward the incoming record when it lands at the head.
        rd_valid_d = (level_d != '0);
        rd_data_d  = (wr_en && (wptr_q == rptr_d)) ? rec : mem_q[rptr_d];
    end

    // Control and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            drop_q     <= '0;
            post_q     <= '0;
            trig_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
            post_q     <= post_d;
            trig_q     <= trig_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Record storage; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_en) begin
            mem_q[wptr_q] <= rec;
        end
    end

    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = rd_data_q;
    assign level_o        = level_q;
    assign drop_cnt_o     = drop_q;
    assign state_o        = 2'(state_q);
    assign triggered_o    = trig_q;
endmodule

// File: tb/tb_brq_rvfi_trace_buffer.sv
// Self-checking bench for brq_rvfi_trace_buffer: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_brq_rvfi_trace_buffer;
    localparam int unsigned Depth = 16;
    localparam int unsigned PostW = 8;
    localparam int unsigned LvlW  = $clog2(Depth + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, cfg_wrap, cfg_trap_only, arm, clear, trig_pc_en, trig_on_trap;
    logic [31:0]       trig_pc;
    logic [PostW-1:0]  post_count;
    logic [LvlW-1:0]   level;
    logic [15:0]       drop_cnt;
    logic [1:0]        state;
    logic              triggered;

    brq_rvfi_trace_buffer_if bus();

    brq_rvfi_trace_buffer #(.Depth(Depth), .PostW(PostW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus            (bus),
        .cfg_wrap_i     (cfg_wrap),
        .cfg_trap_only_i(cfg_trap_only),
        .arm_i          (arm),
        .clear_i        (clear),
        .trig_pc_en_i   (trig_pc_en),
        .trig_pc_i      (trig_pc),
        .trig_on_trap_i (trig_on_trap),
        .post_count_i   (post_count),
        .level_o        (level),
        .drop_cnt_o     (drop_cnt),
        .state_o        (state),
        .triggered_o    (triggered)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a FIFO of records plus the capture state.
    logic [104:0] mq[$];
    int m_drop, m_state, m_post;
    bit m_trig;

    task automatic model_update();
        logic [104:0] r;
        bit pop, trig, keep;
        if (!rst_n || clear) begin
            mq.delete(); m_drop = 0; m_state = 0; m_post = 0; m_trig = 0;
            return;
        end
        r = {bus.rvfi_pc_rdata, bus.rvfi_insn, bus.rvfi_rd_addr, bus.rvfi_rd_wdata,
             bus.rvfi_trap, bus.rvfi_intr, bus.rvfi_mode};
        pop  = (mq.size() != 0) && bus.rd_ready_i;
        trig = (m_state == 1) && bus.rvfi_valid &&
               ((trig_pc_en && bus.rvfi_pc_rdata == trig_pc) || (trig_on_trap && bus.rvfi_trap));
        keep = trig || (bus.rvfi_valid && (m_state == 1 || m_state == 2) &&
                        (!cfg_trap_only || bus.rvfi_trap || bus.rvfi_intr));
        if (pop) void'(mq.pop_front());
        if (keep) begin
            if (mq.size() < Depth) mq.push_back(r);
            else if (cfg_wrap) begin void'(mq.pop_front()); mq.push_back(r); end
            else if (m_drop < 65535) m_drop++;
        end
        if (arm && (m_state == 0 || m_state == 3)) begin
            m_state = 1; m_post = int'(post_count); m_trig = 0;
        end else if (trig) begin
            m_trig = 1; m_state = (m_post == 0) ? 3 : 2;
        end else if (m_state == 2 && keep) begin
            m_post--;
            if (m_post == 0) m_state = 3;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_rec(input logic [31:0] pc, input logic trap, input logic intr);
        bus.rvfi_valid    = 1'b1;
        bus.rvfi_pc_rdata = pc;
        bus.rvfi_insn     = $urandom;
        bus.rvfi_rd_addr  = 5'($urandom);
        bus.rvfi_rd_wdata = $urandom;
        bus.rvfi_trap     = trap;
        bus.rvfi_intr     = intr;
        bus.rvfi_mode     = 2'($urandom);
    endtask

    task automatic idle_rec();
        bus.rvfi_valid = 1'b0;
        bus.rvfi_trap  = 1'b0;
        bus.rvfi_intr  = 1'b0;
    endtask

    task automatic restart(input logic wrap, input logic trap_only, input logic [PostW-1:0] post);
        idle_rec();
        bus.rd_ready_i = 1'b0;
        trig_pc_en = 1'b0; trig_on_trap = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        cfg_wrap = wrap; cfg_trap_only = trap_only; post_count = post;
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        n_total++; if (level !== '0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
        n_total++; if (bus.rd_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.rd_valid_o); else n_pass++;
        n_total++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
        n_total++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt); else n_pass++;
        n_total++; if (triggered !== 1'b0) $display("FAIL reset_trig: got %b want 0", triggered); else n_pass++;
    endtask

    task automatic test_fill(input logic wrap);
        int first;
        restart(wrap, 1'b0, '0);
        for (int i = 0; i < 20; i++) begin set_rec(32'h1000 + 32'(4 * i), 1'b0, 1'b0); tick(); end
        idle_rec();
        first = wrap ? 4 : 0;
        n_total++; if (level !== LvlW'(16)) $display("FAIL fill_level wrap=%b: got %0d want 16", wrap, level); else n_pass++;
        n_total++; if (drop_cnt !== (wrap ? 16'd0 : 16'd4)) $display("FAIL fill_drop wrap=%b: got %0d want %0d", wrap, drop_cnt, wrap ? 0 : 4); else n_pass++;
        bus.rd_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (bus.rd_data_o[104:73] !== 32'h1000 + 32'(4 * (i + first)))
                $display("FAIL fill_pop%0d wrap=%b: got %h want %h", i, wrap, bus.rd_data_o[104:73], 32'h1000 + 32'(4 * (i + first)));
            else n_pass++;
            tick();
        end
        bus.rd_ready_i = 1'b0;
        n_total++; if (bus.rd_valid_o !== 1'b0 || level !== '0) $display("FAIL fill_empty wrap=%b: got valid=%b level=%0d want 0/0", wrap, bus.rd_valid_o, level); else n_pass++;
    endtask

    task automatic test_trigger();
        logic [31:0] pcs [7];
        int exp_st [7];
        pcs = '{32'hF8, 32'hFC, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
        exp_st = '{1, 1, 2, 2, 2, 3, 3};
        restart(1'b0, 1'b0, 8'd3);
        trig_pc_en = 1'b1; trig_pc = 32'h0000_0100;
        for (int i = 0; i < 7; i++) begin
            set_rec(pcs[i], 1'b0, 1'b0); tick();
            n_total++; if (state !== 2'(exp_st[i])) $display("FAIL trig_state%0d: got %0d want %0d", i, state, exp_st[i]); else n_pass++;
        end
        idle_rec(); trig_pc_en = 1'b0;
        n_total++; if (triggered !== 1'b1) $display("FAIL trig_sticky: got %b want 1", triggered); else n_pass++;
        n_total++; if (level !== LvlW'(6)) $display("FAIL trig_level: got %0d want 6", level); else n_pass++;
        bus.rd_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_total++; if (bus.rd_data_o[104:73] !== pcs[i]) $display("FAIL trig_pop%0d: got %h want %h", i, bus.rd_data_o[104:73], pcs[i]); else n_pass++;
            tick();
        end
        bus.rd_ready_i = 1'b0;
        n_total++; if (state !== 2'd3 || bus.rd_valid_o !== 1'b0) $display("FAIL trig_after_drain: got state=%0d valid=%b want 3/0", state, bus.rd_valid_o); else n_pass++;
    endtask

    task automatic test_trap_filter();
        logic [31:0] exp_pc [2];
        exp_pc = '{32'h300C, 32'h301C};
        restart(1'b0, 1'b1, '0);
        for (int i = 0; i < 10; i++) begin set_rec(32'h3000 + 32'(4 * i), (i == 3 || i == 7), 1'b0); tick(); end
        idle_rec();
        n_total++; if (level !== LvlW'(2)) $display("FAIL filt_level: got %0d want 2", level); else n_pass++;
        bus.rd_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_total++; if (bus.rd_data_o[104:73] !== exp_pc[i] || bus.rd_data_o[3] !== 1'b1)
                $display("FAIL filt_pop%0d: got pc=%h trap=%b want %h/1", i, bus.rd_data_o[104:73], bus.rd_data_o[3], exp_pc[i]);
            else n_pass++;
            tick();
        end
        bus.rd_ready_i = 1'b0;
    endtask

    task automatic test_full_push_pop();
        restart(1'b0, 1'b0, '0);
        for (int i = 0; i < 16; i++) begin set_rec(32'h2000 + 32'(4 * i), 1'b0, 1'b0); tick(); end
        set_rec(32'h2040, 1'b0, 1'b0); bus.rd_ready_i = 1'b1; tick();
        idle_rec(); bus.rd_ready_i = 1'b0;
        n_total++; if (level !== LvlW'(16)) $display("FAIL pp_level: got %0d want 16", level); else n_pass++;
        n_total++; if (drop_cnt !== 16'd0) $display("FAIL pp_drop: got %0d want 0", drop_cnt); else n_pass++;
        bus.rd_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_total++; if (bus.rd_data_o[104:73] !== 32'h2004 + 32'(4 * i))
                $display("FAIL pp_pop%0d: got %h want %h", i, bus.rd_data_o[104:73], 32'h2004 + 32'(4 * i));
            else n_pass++;
            tick();
        end
        bus.rd_ready_i = 1'b0;
    endtask

    task automatic test_clear_reset();
        restart(1'b0, 1'b0, '0);
        for (int i = 0; i < 18; i++) begin set_rec(32'h4000 + 32'(4 * i), 1'b0, 1'b0); tick(); end
        idle_rec(); bus.rd_ready_i = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        bus.rd_ready_i = 1'b0;
        n_total++; if (level !== LvlW'(5) || drop_cnt !== 16'd2) $display("FAIL clr_pre: got level=%0d drop=%0d want 5/2", level, drop_cnt); else n_pass++;
        set_rec(32'h5000, 1'b0, 1'b0); bus.rd_ready_i = 1'b1; clear = 1'b1; tick();
        clear = 1'b0; idle_rec(); bus.rd_ready_i = 1'b0;
        n_total++; if (level !== '0 || bus.rd_valid_o !== 1'b0) $display("FAIL clr_buf: got level=%0d valid=%b want 0/0", level, bus.rd_valid_o); else n_pass++;
        n_total++; if (state !== 2'd0 || drop_cnt !== 16'd0) $display("FAIL clr_ctl: got state=%0d drop=%0d want 0/0", state, drop_cnt); else n_pass++;

        restart(1'b0, 1'b0, 8'd5);
        trig_on_trap = 1'b1;
        for (int i = 0; i < 3; i++) begin set_rec(32'h6000 + 32'(4 * i), (i == 1), 1'b0); tick(); end
        n_total++; if (state !== 2'd2 || triggered !== 1'b1) $display("FAIL rst_pre: got state=%0d trig=%b want 2/1", state, triggered); else n_pass++;
        set_rec(32'h7000, 1'b1, 1'b0); bus.rd_ready_i = 1'b1; rst_n = 1'b0; tick();
        rst_n = 1'b1; idle_rec(); bus.rd_ready_i = 1'b0; trig_on_trap = 1'b0;
        n_total++; if (level !== '0 || bus.rd_valid_o !== 1'b0) $display("FAIL rst_buf: got level=%0d valid=%b want 0/0", level, bus.rd_valid_o); else n_pass++;
        n_total++; if (state !== 2'd0 || triggered !== 1'b0 || drop_cnt !== 16'd0)
            $display("FAIL rst_ctl: got state=%0d trig=%b drop=%0d want 0/0/0", state, triggered, drop_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int rdy_pct;
        clear = 1'b1; tick(); clear = 1'b0;
        trig_pc = 32'h0000_0100;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin cfg_wrap = 1'($urandom); cfg_trap_only = ($urandom_range(0, 3) == 0); end
            if (c % 100 == 0) begin trig_pc_en = 1'($urandom); trig_on_trap = 1'($urandom); end
            rdy_pct = ((c / 300) % 2 == 0) ? 2 : 7;
            if ($urandom_range(0, 9) < 7)
                set_rec(($urandom_range(0, 7) == 0) ? 32'h100 : (32'($urandom_range(0, 255)) << 2),
                        ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) == 0));
            else idle_rec();
            bus.rd_ready_i = ($urandom_range(0, 9) < rdy_pct);
            arm        = ($urandom_range(0, 39) == 0);
            post_count = PostW'($urandom_range(0, 6));
            clear      = ($urandom_range(0, 299) == 0);
            rst_n      = ($urandom_range(0, 499) != 0);
            tick();
            n_total++; if (level !== LvlW'(mq.size())) $display("FAIL rnd_level c=%0d: got %0d want %0d", c, level, mq.size()); else n_pass++;
            n_total++; if (drop_cnt !== 16'(m_drop)) $display("FAIL rnd_drop c=%0d: got %0d want %0d", c, drop_cnt, m_drop); else n_pass++;
            n_total++; if (state !== 2'(m_state)) $display("FAIL rnd_state c=%0d: got %0d want %0d", c, state, m_state); else n_pass++;
            n_total++; if (triggered !== m_trig) $display("FAIL rnd_trig c=%0d: got %b want %b", c, triggered, m_trig); else n_pass++;
            n_total++; if (bus.rd_valid_o !== (mq.size() != 0)) $display("FAIL rnd_valid c=%0d: got %b want %b", c, bus.rd_valid_o, mq.size() != 0); else n_pass++;
            if (mq.size() != 0) begin
                n_total++; if (bus.rd_data_o !== mq[0]) $display("FAIL rnd_data c=%0d: got %h want %h", c, bus.rd_data_o, mq[0]); else n_pass++;
            end
        end
        idle_rec(); arm = 1'b0; clear = 1'b0; rst_n = 1'b1; bus.rd_ready_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_wrap = 1'b0; cfg_trap_only = 1'b0; arm = 1'b0; clear = 1'b0;
        trig_pc_en = 1'b0; trig_on_trap = 1'b0; trig_pc = '0; post_count = '0;
        bus.rvfi_valid = 1'b0; bus.rvfi_pc_rdata = '0; bus.rvfi_insn = '0; bus.rvfi_rd_addr = '0;
        bus.rvfi_rd_wdata = '0; bus.rvfi_trap = 1'b0; bus.rvfi_intr = 1'b0; bus.rvfi_mode = '0;
        bus.rd_ready_i = 1'b0;
        m_drop = 0; m_state = 0; m_post = 0; m_trig = 0;
        test_reset();
        test_fill(1'b0);
        test_fill(1'b1);
        test_trigger();
        test_trap_filter();
        test_full_push_pop();
        test_clear_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/brq_rvfi_trace_buffer.md
Name: brq_rvfi_trace_buffer

Overview:
Parametrised on-chip retirement trace capture for the brq core. It samples the RVFI retirement stream alongside the core and stores filtered records in a Depth-entry buffer. The buffer runs in stop-when-full or circular mode. An arm/trigger/post-trigger state machine freezes capture around an event of interest. Stored records are drained through a valid/ready read port, which lets simulation, FPGA or debug logic get instruction traces without a text tracer.

Parameters:
Depth, 16, buffer entries; power of two, >= 2
PostW, 8, width of post-trigger record count
LvlW, $clog2(Depth+1), width of level_o (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
rvfi_valid  in  1  retirement strobe
rvfi_pc_rdata  in  32  retired PC
rvfi_insn  in  32  retired instruction
rvfi_rd_addr  in  5  destination register
rvfi_rd_wdata  in  32  destination write data
rvfi_trap  in  1  retirement trapped
rvfi_intr  in  1  first instruction of handler
rvfi_mode  in  2  privilege mode
cfg_wrap_i  in  1  1 = circular (overwrite oldest), 0 = stop-when-full
cfg_trap_only_i  in  1  capture only records with trap or intr set
arm_i  in  1  pulse: start capture
clear_i  in  1  pulse: flush buffer, counters, state
trig_pc_en_i  in  1  enable PC-match trigger
trig_pc_i  in  32  trigger PC
trig_on_trap_i  in  1  enable trap trigger
post_count_i  in  PostW  records to capture after trigger; sampled on arm
rd_ready_i  in  1  consumer ready
rd_valid_o  out  1  buffer non-empty
rd_data_o  out  105  {pc[104:73], insn[72:41], rd_addr[40:36], rd_wdata[35:4], trap[3], intr[2], mode[1:0]}
level_o  out  LvlW  entries held, 0..Depth
drop_cnt_o  out  16  records lost to a full buffer; saturates at 16'hFFFF
state_o  out  2  0 IDLE, 1 RUN, 2 POST, 3 FROZEN
triggered_o  out  1  sticky; trigger has fired since arm

Behaviour:
- Reset (rst_ni low at clk_i edge) is identical to clear_i:
  - state IDLE; write and read pointers 0; level_o 0; rd_valid_o 0.
  - drop_cnt_o 0; triggered_o 0; post counter 0; rd_data_o don't-care.
- Priority each cycle: reset > clear_i > arm_i > capture/pop.
- arm_i in IDLE or FROZEN:
  - go to RUN; latch post_count_i; clear triggered_o.
  - Buffer contents and drop_cnt_o are kept.
  - arm_i in RUN or POST is ignored.
- Qualified record: rvfi_valid=1, state RUN or POST, and (cfg_trap_only_i=0 or rvfi_trap|rvfi_intr).
- Trigger event, RUN only: rvfi_valid=1 and ((trig_pc_en_i and rvfi_pc_rdata==trig_pc_i) or (trig_on_trap_i and rvfi_trap)).
  - The trigger record is captured even if the filter would reject it.
- Transitions:
  - RUN -> POST on a trigger event; triggered_o <= 1.
  - If the latched count is 0, RUN -> FROZEN directly after capturing the trigger record.
  - POST: each captured record decrements the counter; the capture that takes it to 0 moves state to FROZEN.
  - FROZEN: no capture; reads continue.
- Write path:
  - A captured record is written at the sampling edge.
  - Visible on rd_data_o/rd_valid_o from the next cycle (one cycle of latency).
- Full buffer (level==Depth), no pop in the same cycle:
  - Stop mode: record dropped; drop_cnt_o += 1, saturating.
  - Circular mode: oldest entry overwritten; read pointer advances; level stays Depth; no drop count.
  - Trigger/post counting proceeds for dropped records exactly as if they had been captured.
- Read path:
  - First-word-fall-through. rd_valid_o = (level != 0) in every state.
  - rd_data_o = entry at the read pointer.
  - Pop when rd_valid_o and rd_ready_i.
- Simultaneous push and pop: both occur and level is unchanged. A full buffer plus pop in stop mode therefore accepts the push with no drop.
- Pointers are log2(Depth) bits and wrap modulo Depth.
- level_o is only ever 0..Depth; it never underflows or overflows.
- rvfi_valid while IDLE or FROZEN: ignored; no drop count.

Test Plan:
- Stop mode, Depth=16, RUN, 20 back-to-back retirements, rd_ready_i=0 -> level_o=16, drop_cnt_o=4; pops return PCs of records 0..15 in order.
- Circular mode, same stimulus -> level_o=16, drop_cnt_o=0; first pop returns record 4 and the last returns record 19.
- trig_pc_i=32'h0000_0100, post_count_i=3, PC stream 0xF8,0xFC,0x100,0x104,0x108,0x10C,0x110 -> state RUN->POST at 0x100, FROZEN after 0x10C, triggered_o=1; 0x110 not stored; level_o=6.
- cfg_trap_only_i=1, 10 retirements with rvfi_trap=1 on records 3 and 7 -> level_o=2; stored PCs are records 3 and 7.
- Buffer full, stop mode, push and pop on the same edge -> level_o stays 16, drop_cnt_o unchanged, new record lands at the tail.
- clear_i asserted on the same edge as rvfi_valid and rd_ready_i with 5 entries held -> next cycle level_o=0, rd_valid_o=0, state_o=0, drop_cnt_o=0; repeat the check using rst_ni=0 mid-capture.
